// File: rtl/rv_pkg.sv
// Shared RISC-V core types and sizes used across the integer datapath.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : rv_pkg

// File: rtl/rf_read_port.sv
// Combinational 32:1 register read mux; address 0 always returns zero.
module rf_read_port
  import rv_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data_c
);

  always_comb begin
    rd_data_c = '0;
    if (addr != '0) begin
      rd_data_c = regs[addr];
    end
  end

endmodule : rf_read_port

// File: rtl/register_file.sv
// Integer register file: two async read ports, one sync write port, x0 tied to zero.
module register_file
  import rv_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] addr_1_i,
  input  logic [ADDR_W-1:0] addr_2_i,
  input  logic [ADDR_W-1:0] addr_3_i,
  input  logic              WE3_i,
  input  logic [DATA_W-1:0] WD3_i,
  output logic [DATA_W-1:0] RD_1_o,
  output logic [DATA_W-1:0] RD_2_o
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  we_vec;

  // One-hot write decode; x0 never gets an enable
  always_comb begin
    we_vec = '0;
    if (WE3_i && (addr_3_i != '0)) begin
      we_vec[addr_3_i] = 1'b1;
    end
  end

  // Reset has priority, so an edge coinciding with reset writes nothing
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < int'(NREGS); i++) begin
        if (we_vec[i]) begin
          mem[i] <= WD3_i;
        end
      end
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_1 (
    .regs      (mem),
    .addr      (addr_1_i),
    .rd_data_c (RD_1_o)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_2 (
    .regs      (mem),
    .addr      (addr_2_i),
    .rd_data_c (RD_2_o)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed vector bench for register_file: table of writes/reads plus reset and RDW sequences.
module tb_register_file;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  addr_1_i, addr_2_i, addr_3_i;
  logic        WE3_i;
  logic [31:0] WD3_i;
  logic [31:0] RD_1_o, RD_2_o;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  register_file dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .addr_1_i (addr_1_i),
    .addr_2_i (addr_2_i),
    .addr_3_i (addr_3_i),
    .WE3_i    (WE3_i),
    .WD3_i    (WD3_i),
    .RD_1_o   (RD_1_o),
    .RD_2_o   (RD_2_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge
  task automatic write_cycle(input logic we, input logic [4:0] a3, input logic [31:0] wd);
    @(negedge clk_i);
    WE3_i    = we;
    addr_3_i = a3;
    WD3_i    = wd;
    @(posedge clk_i);
    #1;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 5'd1, 32'h0000_0001, 5'd1, 5'd2, 32'h0000_0001, 32'h0000_0000};
    vecs[1] = '{1'b1, 5'd2, 32'h0000_0001, 5'd1, 5'd2, 32'h0000_0001, 32'h0000_0001};
    vecs[2] = '{1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b1, 5'd5, 32'h0000_0001, 5'd0, 5'd1, 32'h0000_0000, 32'h0000_0001};
    vecs[4] = '{1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd5, 32'h0000_0000, 32'h0000_0001};
    vecs[5] = '{1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd0, 32'hCAFE_F00D, 32'h0000_0000};
    vecs[6] = '{1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[7] = '{1'b1, 5'd3, 32'h0000_000A, 5'd3, 5'd2, 32'h0000_000A, 32'h0000_0001};

    reset_i  = 1'b1;
    WE3_i    = 1'b0;
    addr_3_i = 5'd0;
    WD3_i    = '0;
    addr_1_i = 5'd3;
    addr_2_i = 5'd31;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_rd1", RD_1_o, 32'h0);
    check("reset_rd2", RD_2_o, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      addr_1_i = vecs[i].a1;
      addr_2_i = vecs[i].a2;
      write_cycle(vecs[i].we, vecs[i].a3, vecs[i].wd);
      check($sformatf("vec%0d_rd1", i), RD_1_o, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), RD_2_o, vecs[i].exp2);
    end

    // Read-during-write: old value before the edge, new value after
    @(negedge clk_i);
    WE3_i    = 1'b1;
    addr_3_i = 5'd3;
    WD3_i    = 32'h0000_000B;
    addr_1_i = 5'd3;
    #1;
    check("rdw_before", RD_1_o, 32'h0000_000A);
    @(posedge clk_i);
    #1;
    check("rdw_after", RD_1_o, 32'h0000_000B);

    // Async reset mid-cycle, then a write attempted while held in reset
    @(negedge clk_i);
    WE3_i    = 1'b0;
    addr_1_i = 5'd1;
    addr_2_i = 5'd2;
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_rd1", RD_1_o, 32'h0);
    check("async_rst_rd2", RD_2_o, 32'h0);
    addr_1_i = 5'd5;
    write_cycle(1'b1, 5'd5, 32'h0000_0001);
    check("rst_write_blocked", RD_1_o, 32'h0);
    @(negedge clk_i);
    WE3_i   = 1'b0;
    reset_i = 1'b0;
    #1;
    check("post_rst_reg5", RD_1_o, 32'h0);
    addr_2_i = 5'd7;
    #1;
    check("post_rst_reg7", RD_2_o, 32'h0);
    addr_1_i = 5'd4;
    write_cycle(1'b1, 5'd4, 32'h0000_0055);
    check("first_write_after_rst", RD_1_o, 32'h0000_0055);

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      write_cycle(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
    end
    @(negedge clk_i);
    WE3_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addr_1_i = 5'(i);
      addr_2_i = 5'(31 - i);
      #1;
      check($sformatf("sweep_rd1_%0d", i), RD_1_o, (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101);
      check($sformatf("sweep_rd2_%0d", 31 - i), RD_2_o,
            (i == 31) ? 32'h0 : 32'(31 - i) * 32'h0101_0101);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_register_file
